// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Brief    : Debounces the mode/inc buttons and sequences the binary clock's
//            RUN -> SET_HOURS -> SET_MINUTES -> COMMIT time-set cycle.
// Revision : 1.0
// ============================================================================
module clock_set_ctrl #(
    parameter int DB_CYCLES      = 16,
    parameter int REPEAT_DELAY   = 256,
    parameter int REPEAT_PERIOD  = 64,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int BLINK_BITS     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       hold,
    output logic       load,
    output logic       clear_seconds,
    output logic [4:0] load_hours,
    output logic [5:0] load_minutes,
    output logic [1:0] blink_mask,
    output logic [1:0] state_out
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0] c_db_max       = DB_W'(DB_CYCLES);
    localparam logic [RP_W-1:0] c_rp_delay_end = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] c_rp_per_end   = RP_W'(REPEAT_PERIOD - 1);
    localparam logic [TO_W-1:0] c_to_end       = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      c_hours_max    = 5'd23;
    localparam logic [5:0]      c_minutes_max  = 6'd59;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SET_H  = 2'd1,
        ST_SET_M  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Button vectors: bit 1 = inc, bit 0 = mode.
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      db_level_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [1:0]      w_settled;
    logic [1:0]      w_press;
    logic            w_inc_release;

    logic [RP_W-1:0] rep_cnt_q;
    logic            rep_armed_q;
    logic            rep_fast_q;
    logic [RP_W-1:0] w_rep_end;
    logic            w_rep_ev;

    state_t          state_q;
    state_t          state_d;
    logic [4:0]      edit_h_q;
    logic [4:0]      edit_h_d;
    logic [5:0]      edit_m_q;
    logic [5:0]      edit_m_d;
    logic [TO_W-1:0] idle_q;
    logic [TO_W-1:0] idle_d;
    logic [BLINK_BITS-1:0] blink_q;

    logic            w_edit;
    logic            w_mode_ev;
    logic            w_inc_ev;
    logic [4:0]      w_h_next;
    logic [5:0]      w_m_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_inc, btn_mode};
            sync2_q <= sync1_q;
        end
    end

    // A level only flips after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_level_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == c_db_max) begin
                    db_level_q[i] <= sync2_q[i];
                    db_cnt_q[i]   <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_settle
        assign w_settled[gi] = (sync2_q[gi] != db_level_q[gi]) && (db_cnt_q[gi] == c_db_max);
    end

    assign w_press       = w_settled & sync2_q;
    assign w_inc_release = w_settled[1] & ~sync2_q[1];

    assign w_edit    = (state_q == ST_SET_H) || (state_q == ST_SET_M);
    assign w_rep_end = rep_fast_q ? c_rp_per_end : c_rp_delay_end;
    assign w_rep_ev  = w_edit && rep_armed_q && db_level_q[1] && !w_inc_release
                       && (rep_cnt_q == w_rep_end);

    // Auto-repeat is armed only by a press taken while editing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            rep_fast_q  <= 1'b0;
        end else if (w_edit && w_press[1]) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b1;
            rep_fast_q  <= 1'b0;
        end else if (!w_edit || !db_level_q[1] || w_inc_release) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            rep_fast_q  <= 1'b0;
        end else if (rep_armed_q) begin
            if (w_rep_ev) begin
                rep_cnt_q  <= '0;
                rep_fast_q <= 1'b1;
            end else begin
                rep_cnt_q <= rep_cnt_q + RP_W'(1);
            end
        end
    end

    assign w_mode_ev = w_press[0];
    assign w_inc_ev  = w_press[1] | w_rep_ev;
    assign w_h_next  = (edit_h_q >= c_hours_max)   ? 5'd0 : edit_h_q + 5'd1;
    assign w_m_next  = (edit_m_q >= c_minutes_max) ? 6'd0 : edit_m_q + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            edit_h_q <= '0;
            edit_m_q <= '0;
            idle_q   <= '0;
            blink_q  <= '0;
        end else begin
            state_q  <= state_d;
            edit_h_q <= edit_h_d;
            edit_m_q <= edit_m_d;
            idle_q   <= idle_d;
            blink_q  <= blink_q + BLINK_BITS'(1);
        end
    end

    // Mode takes priority over inc; idle count restarts on any accepted event.
    always_comb begin
        state_d  = state_q;
        edit_h_d = edit_h_q;
        edit_m_d = edit_m_q;
        idle_d   = '0;
        case (state_q)
            ST_RUN: begin
                if (w_mode_ev) begin
                    edit_h_d = cur_hours;
                    edit_m_d = cur_minutes;
                    state_d  = ST_SET_H;
                end
            end
            ST_SET_H: begin
                if (w_mode_ev) begin
                    state_d = ST_SET_M;
                end else if (w_inc_ev) begin
                    edit_h_d = w_h_next;
                end else if (idle_q == c_to_end) begin
                    state_d = ST_RUN;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            ST_SET_M: begin
                if (w_mode_ev) begin
                    state_d = ST_COMMIT;
                end else if (w_inc_ev) begin
                    edit_m_d = w_m_next;
                end else if (idle_q == c_to_end) begin
                    state_d = ST_RUN;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign hold          = (state_q != ST_RUN);
    assign load          = (state_q == ST_COMMIT);
    assign clear_seconds = (state_q == ST_COMMIT);
    assign load_hours    = edit_h_q;
    assign load_minutes  = edit_m_q;
    assign blink_mask    = {(state_q == ST_SET_H) & blink_q[BLINK_BITS-1],
                            (state_q == ST_SET_M) & blink_q[BLINK_BITS-1]};
    assign state_out     = state_q;

endmodule
`default_nettype wire
